parking_slot_manager: RTL

PARKING_SLOT_MANAGER -- requirements
Module: parking_slot_manager

---
 rtl/parking_slot_manager.sv | 123 ++++++++++++
 1 files changed

// File: rtl/parking_slot_manager.sv
// Four-slot parking entry controller.
// An arriving car is given the lowest-numbered free slot and the entry gate
// opens. The reservation stands once the car clears the gate, or is dropped
// if the gate times out first. Departures free their slots. Departures that
// name an empty slot, or the slot still being entered, are rejected.
//
// Handshake: arrive_req is a level held by the entry sensor. The block
// accepts it with a one-cycle arrive_ack, and slot_id is valid in that same
// cycle. A request that stays high in IDLE after an ack is a new car.
// gate_passed and depart_valid are single-cycle pulses.
module parking_slot_manager #(
   parameter int unsigned GATE_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       arrive_req,
   output logic       arrive_ack,
   output logic [1:0] slot_id,
   output logic       gate_open,
   input  logic       gate_passed,
   input  logic       depart_valid,
   input  logic [1:0] depart_slot,
   output logic [3:0] occupied,
   output logic       full,
   output logic       timeout,
   output logic       err_depart,
   output logic       fsm_state
);

   typedef enum logic {IDLE = 1'b0, GATE = 1'b1} state_t;

   localparam logic [7:0] TIMER_LOAD = 8'(GATE_TIMEOUT);

   state_t     state, state_n;
   logic [7:0] timer, timer_n;
   logic [3:0] occ_n;
   logic [1:0] slot_n;
   logic       ack_n, timeout_n, err_n;
   logic [1:0] alloc_idx;
   logic       depart_legal;

   // Full is taken straight from the occupancy register, with no extra delay.
   assign full      = &occupied;
   assign gate_open = (state == GATE);
   assign fsm_state = state;

   // Lowest-index free slot, based on occupancy before this edge.
   always_comb begin
      alloc_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!occupied[i]) alloc_idx = 2'(i);
      end
   end

   // A departure is legal only for an occupied slot that is not being entered right now.
   always_comb begin
      depart_legal = depart_valid && occupied[depart_slot]
                     && !((state == GATE) && (depart_slot == slot_id));
   end

   // Next-state, occupancy, timer and pulse decisions.
   always_comb begin
      state_n   = state;
      timer_n   = timer;
      occ_n     = occupied;
      slot_n    = slot_id;
      ack_n     = 1'b0;
      timeout_n = 1'b0;
      err_n     = depart_valid && !depart_legal;

      if (depart_legal) occ_n[depart_slot] = 1'b0;

      case (state)
         IDLE: begin
            if (arrive_req && !full) begin
               occ_n[alloc_idx] = 1'b1;
               slot_n           = alloc_idx;
               ack_n            = 1'b1;
               timer_n          = TIMER_LOAD;
               state_n          = GATE;
            end
         end
         GATE: begin
            // A pass wins over an expiry that happens in the same cycle.
            if (gate_passed) begin
               state_n = IDLE;
               timer_n = 8'd0;
            end else if (timer <= 8'd1) begin
               // This is the last open cycle: the timer hits zero and the slot is released.
               state_n          = IDLE;
               timer_n          = 8'd0;
               timeout_n        = 1'b1;
               occ_n[slot_id]   = 1'b0;
            end else begin
               timer_n = timer - 8'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State and output registers. Reset overrides every event in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         timer      <= 8'd0;
         occupied   <= 4'd0;
         slot_id    <= 2'd0;
         arrive_ack <= 1'b0;
         timeout    <= 1'b0;
         err_depart <= 1'b0;
      end else begin
         state      <= state_n;
         timer      <= timer_n;
         occupied   <= occ_n;
         slot_id    <= slot_n;
         arrive_ack <= ack_n;
         timeout    <= timeout_n;
         err_depart <= err_n;
      end
   end

endmodule
